// File: rtl/vdp_vram_sched.sv
// Shares one single-port VRAM between tile fetch (slots ccc=0..2 in the window) and a CPU port.
// Fetch never yields; CPU writes/read-aheads wait for the next CPU slot, acks are one-cycle pulses.
module vdp_vram_sched (
  input  logic        pxclk,
  input  logic        reset,
  input  logic [8:0]  col_in,
  input  logic [9:0]  row_in,
  input  logic [3:0]  name_base,
  input  logic [2:0]  pattern_base,
  input  logic [7:0]  color_base,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_mode,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  name_q,
  output logic [7:0]  pattern_q,
  output logic [7:0]  color_q,
  output logic        tile_valid
);

  typedef enum logic [1:0] {IDLE, PEND_WR, PEND_RD, RD_DATA} state_t;

  state_t      state;
  logic [13:0] addr;
  logic        toggle;
  logic [7:0]  rdbuf;
  logic [7:0]  wdata_r;

  logic [2:0]  ccc;
  logic        in_window;
  logic        cpu_slot;
  logic        wr_issue;
  logic        accept;
  logic        unused_nn;

  assign ccc       = col_in[2:0];
  assign in_window = !col_in[8] && (row_in[9:8] != 2'b11);
  assign cpu_slot  = !(in_window && (ccc < 3'd3));
  assign wr_issue  = reset && (state == PEND_WR) && cpu_slot;
  assign accept    = (state == IDLE) && cpu_req && !cpu_ack;
  assign unused_nn = ^row_in[1:0];

  // Pattern address uses the name byte straight off the VRAM bus, one cycle ahead of name_q.
  always_comb begin
    vram_addr = addr;
    if (in_window) begin
      case (ccc)
        3'd0:    vram_addr = {name_base, row_in[9:5], col_in[7:3]};
        3'd1:    vram_addr = {pattern_base, vram_rdata, row_in[4:2]};
        3'd2:    vram_addr = {color_base, 1'b0, name_q[7:3]};
        default: vram_addr = addr;
      endcase
    end
    if (!reset) vram_addr = 14'h0000;
  end

  assign vram_we    = wr_issue;
  assign vram_wdata = wr_issue ? wdata_r : 8'h00;

  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= 14'h0000;
      toggle     <= 1'b0;
      rdbuf      <= 8'h00;
      wdata_r    <= 8'h00;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= 8'h00;
      name_q     <= 8'h00;
      pattern_q  <= 8'h00;
      color_q    <= 8'h00;
      tile_valid <= 1'b0;
    end else begin
      cpu_ack    <= 1'b0;
      tile_valid <= in_window && (ccc == 3'd3);
      if (in_window) begin
        case (ccc)
          3'd1:    name_q    <= vram_rdata;
          3'd2:    pattern_q <= vram_rdata;
          3'd3:    color_q   <= vram_rdata;
          default: ;
        endcase
      end

      case (state)
        IDLE: begin
          if (accept) begin
            if (cpu_mode) begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= 8'h00;
              if (cpu_we) begin
                if (!toggle) begin
                  addr[7:0] <= cpu_wdata;
                  toggle    <= 1'b1;
                end else begin
                  addr[13:8] <= cpu_wdata[5:0];
                  toggle     <= 1'b0;
                  if (!cpu_wdata[6]) state <= PEND_RD;
                end
              end else begin
                toggle <= 1'b0;
              end
            end else begin
              toggle <= 1'b0;
              if (cpu_we) begin
                wdata_r <= cpu_wdata;
                state   <= PEND_WR;
              end else begin
                cpu_ack   <= 1'b1;
                cpu_rdata <= rdbuf;
                state     <= PEND_RD;
              end
            end
          end
        end
        PEND_WR: begin
          if (cpu_slot) begin
            addr      <= addr + 14'd1;
            cpu_ack   <= 1'b1;
            cpu_rdata <= 8'h00;
            state     <= IDLE;
          end
        end
        PEND_RD: begin
          if (cpu_slot) state <= RD_DATA;
        end
        RD_DATA: begin
          rdbuf <= vram_rdata;
          addr  <= addr + 14'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_vram_sched.sv
// Bench for vdp_vram_sched: VRAM model, CPU transfer table with write/ack scoreboards, tile-slot sequences.
module tb_vdp_vram_sched;

  logic        pxclk = 1'b0;
  logic        reset;
  logic [8:0]  col_in;
  logic [9:0]  row_in;
  logic [3:0]  name_base;
  logic [2:0]  pattern_base;
  logic [7:0]  color_base;
  logic        cpu_req, cpu_we, cpu_mode;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;
  logic [7:0]  name_q, pattern_q, color_q;
  logic        tile_valid;

  int total = 0;
  int bad   = 0;

  always #5 pxclk = ~pxclk;

  vdp_vram_sched dut (
    .pxclk(pxclk), .reset(reset), .col_in(col_in), .row_in(row_in),
    .name_base(name_base), .pattern_base(pattern_base), .color_base(color_base),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_mode(cpu_mode), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .name_q(name_q), .pattern_q(pattern_q), .color_q(color_q), .tile_valid(tile_valid)
  );

  // Synchronous single-port VRAM; preload port used only while the DUT is in reset.
  logic [7:0]  mem [0:16383];
  logic        pre_we = 1'b0;
  logic [13:0] pre_addr = 14'h0;
  logic [7:0]  pre_dat = 8'h0;

  always @(posedge pxclk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    else if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct { logic [13:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic c; logic [7:0] d; } ack_t;
  wr_t  wq[$];
  ack_t aq[$];

  always @(negedge pxclk) begin
    if (vram_we) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h required=no write", vram_addr, vram_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("write_addr", {18'h0, vram_addr}, {18'h0, e.a});
        chk("write_data", {24'h0, vram_wdata}, {24'h0, e.d});
      end
    end
    if (cpu_ack) begin
      total++;
      if (aq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack actual=1 required=0");
      end else begin
        ack_t a;
        a = aq.pop_front();
        if (a.c) chk("read_data", {24'h0, cpu_rdata}, {24'h0, a.d});
      end
    end
  end

  task automatic xfer(input logic m, input logic w, input logic [7:0] d);
    int n;
    cpu_mode = m; cpu_we = w; cpu_wdata = d; cpu_req = 1'b1;
    n = 0;
    do begin @(posedge pxclk); #1; n++; end while (!cpu_ack && n < 40);
    chk("ack_seen", {31'h0, cpu_ack}, 32'h1);
    // Request stays high through the ack cycle and must not be taken again.
    @(posedge pxclk); #1;
    cpu_req = 1'b0;
    repeat (4) @(posedge pxclk);
    #1;
  endtask

  typedef struct {
    logic m; logic w; logic [7:0] d; logic [7:0] rd; logic [13:0] wa; logic [13:0] ea;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'h34, 8'h00, 14'h0000, 14'h0034};
    tbl[1]  = '{1'b1, 1'b1, 8'h52, 8'h00, 14'h0000, 14'h1234};
    tbl[2]  = '{1'b0, 1'b1, 8'hA5, 8'h00, 14'h1234, 14'h1235};
    tbl[3]  = '{1'b0, 1'b1, 8'h5A, 8'h00, 14'h1235, 14'h1236};
    tbl[4]  = '{1'b1, 1'b1, 8'h00, 8'h00, 14'h0000, 14'h1200};
    tbl[5]  = '{1'b1, 1'b1, 8'h00, 8'h00, 14'h0000, 14'h0001};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 8'h11, 14'h0000, 14'h0002};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h22, 14'h0000, 14'h0003};
    tbl[8]  = '{1'b1, 1'b1, 8'h12, 8'h00, 14'h0000, 14'h0012};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 14'h0000, 14'h0012};
    tbl[10] = '{1'b1, 1'b1, 8'hFF, 8'h00, 14'h0000, 14'h00FF};
    tbl[11] = '{1'b1, 1'b1, 8'h7F, 8'h00, 14'h0000, 14'h3FFF};
    tbl[12] = '{1'b0, 1'b1, 8'hC3, 8'h00, 14'h3FFF, 14'h0000};
    tbl[13] = '{1'b0, 1'b1, 8'h41, 8'h00, 14'h0000, 14'h0001};

    // Reset with arbitrary inputs, preloading VRAM meanwhile.
    reset = 1'b0;
    col_in = 9'($urandom); row_in = 10'($urandom);
    name_base = 4'($urandom); pattern_base = 3'($urandom); color_base = 8'($urandom);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_mode = 1'b0; cpu_wdata = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(posedge pxclk); #1;
      pre_we = 1'b1;
      case (i)
        0: begin pre_addr = 14'h0000; pre_dat = 8'h11; end
        1: begin pre_addr = 14'h0001; pre_dat = 8'h22; end
        2: begin pre_addr = 14'h0A08; pre_dat = 8'hF0; end
        default: begin pre_addr = 14'h0208; pre_dat = 8'h1E; end
      endcase
      col_in = 9'($urandom); row_in = 10'($urandom);
      @(negedge pxclk);
      chk("rst_vram", {17'h0, vram_we, vram_addr}, 32'h0);
      chk("rst_wdata_ack", {15'h0, vram_wdata, cpu_ack, cpu_rdata}, 32'h0);
      chk("rst_tile", {tile_valid, name_q, pattern_q, color_q}, 32'h0);
    end
    @(posedge pxclk); #1;
    pre_we = 1'b0;
    cpu_req = 1'b0;
    col_in = 9'h100; row_in = 10'h000;
    name_base = 4'h0; pattern_base = 3'h1; color_base = 8'h08;
    @(posedge pxclk); #1;
    reset = 1'b1;
    repeat (2) @(posedge pxclk);
    #1;
    chk("post_rst_addr", {18'h0, vram_addr}, 32'h0);

    // CPU transfers outside the fetch window.
    for (int i = 0; i < 14; i++) begin
      ack_t a;
      if (!tbl[i].m && tbl[i].w) begin
        wr_t e;
        e.a = tbl[i].wa; e.d = tbl[i].d;
        wq.push_back(e);
      end
      a.c = !tbl[i].w; a.d = tbl[i].rd;
      aq.push_back(a);
      xfer(tbl[i].m, tbl[i].w, tbl[i].d);
      chk($sformatf("idle_addr_%0d", i), {18'h0, vram_addr}, {18'h0, tbl[i].ea});
    end

    // Tile 0 fetch, then tile 1 with a data write requested at ccc=0.
    for (int c = 0; c < 16; c++) begin
      col_in = 9'(c);
      if (c == 8) begin
        wr_t e;
        ack_t a;
        e.a = 14'h0001; e.d = 8'h77;
        wq.push_back(e);
        a.c = 1'b0; a.d = 8'h00;
        aq.push_back(a);
        cpu_mode = 1'b0; cpu_we = 1'b1; cpu_wdata = 8'h77; cpu_req = 1'b1;
      end
      if (c == 13) cpu_req = 1'b0;
      @(negedge pxclk);
      case (c)
        0:  chk("fetch_name_addr", {18'h0, vram_addr}, 32'h0000);
        1:  chk("fetch_pat_addr", {18'h0, vram_addr}, 32'h0A08);
        2:  chk("fetch_col_addr", {18'h0, vram_addr}, 32'h0208);
        4:  chk("tile0_bytes", {8'h0, name_q, pattern_q, color_q}, 32'h0041F01E);
        8:  chk("t1_name_addr", {18'h0, vram_addr}, 32'h0001);
        9:  chk("t1_pat_addr", {18'h0, vram_addr}, 32'h0910);
        10: chk("t1_col_addr", {18'h0, vram_addr}, 32'h0204);
        12: chk("t1_name_q", {24'h0, name_q}, 32'h22);
        default: ;
      endcase
      chk($sformatf("tile_valid_c%0d", c), {31'h0, tile_valid}, {31'h0, ((c % 8) == 4)});
      if (c >= 8) begin
        chk($sformatf("blk_we_c%0d", c), {31'h0, vram_we}, {31'h0, (c == 11)});
        chk($sformatf("blk_ack_c%0d", c), {31'h0, cpu_ack}, {31'h0, (c == 12)});
      end
      @(posedge pxclk); #1;
    end

    // Reset while a write is pending drops the write.
    col_in = 9'd16;
    cpu_mode = 1'b0; cpu_we = 1'b1; cpu_wdata = 8'h99; cpu_req = 1'b1;
    @(posedge pxclk); #1;
    reset = 1'b0; cpu_req = 1'b0;
    for (int c = 17; c < 21; c++) begin
      col_in = 9'(c);
      @(negedge pxclk);
      chk($sformatf("rst_pend_we_c%0d", c), {31'h0, vram_we}, 32'h0);
      @(posedge pxclk); #1;
    end
    reset = 1'b1;
    col_in = 9'h100;
    repeat (4) @(posedge pxclk);
    #1;
    chk("rst_pend_addr", {18'h0, vram_addr}, 32'h0);
    chk("wq_drained", wq.size(), 32'h0);
    chk("aq_drained", aq.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vdp_vram_sched.md
# vdp_vram_sched

Time-slot scheduler that shares one synchronous single-port 16 KB VRAM between the VDP tile fetch path and a CPU port. Each 8-pixel tile period inside the display window reserves three slots: name, pattern and color table reads. The remaining slots, and every cycle outside the window, serve CPU data reads and writes through an auto-incrementing address register with a read-ahead buffer. Fetched tile bytes feed the pixel pipeline. Table base addresses come from register inputs.

## Interface
- No parameters.
- pxclk  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- col_in  in  9  pixel column; `{CCCCC,ccc} = col_in[7:0]`
- row_in  in  10  pixel row; `{RRRRR,rrr,nn} = row_in[9:0]`
- name_base  in  4  VRAM address bits [13:10] of the name table
- pattern_base  in  3  VRAM address bits [13:11] of the pattern table
- color_base  in  8  VRAM address bits [13:6] of the color table
- cpu_req  in  1  CPU request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_mode  in  1  0 = data port, 1 = control port
- cpu_wdata  in  8  CPU write byte
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read byte, valid with cpu_ack
- vram_addr  out  14  VRAM address, combinational in the issuing cycle
- vram_we  out  1  VRAM write strobe
- vram_wdata  out  8  VRAM write byte
- vram_rdata  in  8  VRAM read data, valid the cycle after issue
- name_q, pattern_q, color_q  out  8 each  latched tile bytes
- tile_valid  out  1  pulse: all three bytes updated

## Operation
- Fetch window: `col_in[8]==0 && row_in[9:8]!=2'b11`.
- Slot schedule inside the fetch window, keyed by ccc:
  - ccc=0: issue name read at `{name_base,RRRRR,CCCCC}`.
  - ccc=1: latch name_q from vram_rdata. Issue pattern read at `{pattern_base,vram_rdata,rrr}`.
  - ccc=2: latch pattern_q. Issue color read at `{color_base,name_q[7:3]}`.
  - ccc=3: latch color_q. tile_valid=1 the following cycle.
  - ccc=3..7 are CPU slots.
- Outside the fetch window every cycle is a CPU slot and no fetch occurs.
- CPU state: addr (14 bits), toggle (1 bit), rdbuf (8 bits).
- FSM states: IDLE, PEND_WR, PEND_RD, RD_DATA.
- Control write:
  - toggle=0: addr[7:0]=wdata, toggle=1.
  - toggle=1: addr[13:8]=wdata[5:0], toggle=0. If wdata[6]==0, enter PEND_RD (read-ahead).
  - Acked the next cycle; no VRAM access of its own.
- Control read: ack the next cycle, cpu_rdata=8'h00, toggle=0.
- Data write: toggle=0, enter PEND_WR.
  - At the first CPU slot: vram_addr=addr, vram_we=1, vram_wdata=wdata, addr+=1, ack the next cycle.
- Data read: toggle=0, ack the next cycle with cpu_rdata=rdbuf, then enter PEND_RD.
- PEND_RD: at the first CPU slot, issue a read at addr and go to RD_DATA.
- RD_DATA: rdbuf=vram_rdata, addr+=1, go to IDLE.
- Only IDLE accepts cpu_req. Requests arriving in other states wait, unacknowledged.
- addr increments modulo 2^14: 3FFF→0000.
- vram_we=0 in every non-write cycle.
- vram_addr in idle CPU slots = addr.

## Timing
- Reset (reset=0), asynchronous:
  - name_q, pattern_q, color_q, rdbuf, addr, toggle, cpu_rdata = 0.
  - cpu_ack, tile_valid = 0. State = IDLE.
  - vram_we, vram_addr, vram_wdata forced 0.
- Reset during PEND_WR drops the write; no strobe is issued.
- cpu_ack is high exactly one cycle. The requester drops cpu_req the cycle after ack.
- A request seen high in the ack cycle is not re-accepted.
- Data write latency: the write strobe appears in the first CPU slot at or after the cycle following the request; ack follows one cycle later.
- Worst case inside the window, request at ccc=0: strobe at ccc=3, ack at ccc=4.
- Read-ahead issued at ccc=7 returns in cycle ccc=0. The display does not consume vram_rdata at ccc=0, so there is no conflict.
- Fetch slots never yield to the CPU.
- Window entry or exit mid-tile follows the ccc slot rule cycle by cycle.

## Test plan
- Reset: hold reset=0 with arbitrary inputs → all outputs 0; after release, addr=0 and toggle=0.
- Address plus write, outside window: control writes 8'h34, then 8'h52, then data write 8'hA5 → vram_we=1, vram_addr=14'h1234, vram_wdata=8'hA5, one ack per transfer; next write lands at 14'h1235.
- Read-ahead: preload VRAM[0]=8'h11, VRAM[1]=8'h22; control 8'h00, 8'h00; two data reads → cpu_rdata 8'h11 then 8'h22; addr=2.
- Tile fetch: inputs and VRAM contents:
  - name_base=0, pattern_base=1, color_base=8'h08.
  - row 0, col 0; VRAM[0]=8'h41, VRAM[14'h0A08]=8'hF0, VRAM[14'h0208]=8'h1E.
  - Required: addresses 0000, 0A08, 0208 issued at ccc=0,1,2; name_q=41, pattern_q=F0, color_q=1E; tile_valid at ccc=4.
- Slot blocking: data write requested at ccc=0 inside the window → strobe at ccc=3, ack at ccc=4; the fetch addresses are undisturbed.
- Wrap: set addr 14'h3FFF (control 8'hFF, 8'h7F), data write → write at 3FFF; next write lands at 14'h0000.
